// File: rtl/seq_det_param.sv
// Parametrised serial pattern detector with a run-time reloadable pattern and a registered match
// pulse. Define SEQ_DET_MATCH_CNT_EN to add the saturating match_cnt output.
module seq_det_param #(
  parameter int unsigned          SEQ_LEN = 3,
  parameter logic [SEQ_LEN-1:0]   PATTERN = 3'b101,
  parameter bit                   OVERLAP = 1'b1,
  parameter int unsigned          CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               seqin,
  input  logic               seq_vld,
  input  logic               pat_ld,
  input  logic [SEQ_LEN-1:0] pat_in,
  output logic               dout,
  output logic               armed
`ifdef SEQ_DET_MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0]   match_cnt
`endif
);

  localparam int unsigned FillW = $clog2(SEQ_LEN);
  // Number of bits that must be held before a match can complete.
  localparam logic [FillW-1:0] FillLast = FillW'(SEQ_LEN - 1);

  if (SEQ_LEN < 2 || SEQ_LEN > 16) begin : g_bad_seq_len
    $error("seq_det_param: SEQ_LEN must be in 2..16");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("seq_det_param: CNT_W must be in 1..32");
  end

  typedef enum logic [0:0] {StFill, StArmed} state_e;

  state_e               state_q, state_d;
  logic [SEQ_LEN-2:0]   hist_q, hist_d;
  logic [FillW-1:0]     fill_q, fill_d;
  logic [SEQ_LEN-1:0]   pat_q, pat_d;
  logic                 dout_q;
  logic                 match;
  logic [SEQ_LEN-1:0]   cand;
  logic [SEQ_LEN-2:0]   hist_shift;
  logic [FillW-1:0]     fill_inc;

  always_comb begin
    state_d    = state_q;
    hist_d     = hist_q;
    fill_d     = fill_q;
    pat_d      = pat_q;
    match      = 1'b0;
    cand       = {hist_q, seqin};
    hist_shift = cand[SEQ_LEN-2:0];
    fill_inc   = fill_q + 1'b1;

    if (pat_ld) begin
      pat_d   = pat_in;
      hist_d  = '0;
      fill_d  = '0;
      state_d = StFill;
    end else if (seq_vld) begin
      unique case (state_q)
        StFill: begin
          hist_d = hist_shift;
          fill_d = fill_inc;
          if (fill_inc == FillLast) begin
            state_d = StArmed;
          end
        end
        StArmed: begin
          match = (cand == pat_q);
          if (match && !OVERLAP) begin
            // Non-overlapping: the matched bits may not seed the next match.
            hist_d  = '0;
            fill_d  = '0;
            state_d = StFill;
          end else begin
            hist_d = hist_shift;
          end
        end
        default: begin
          hist_d  = '0;
          fill_d  = '0;
          state_d = StFill;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFill;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= PATTERN;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      dout_q  <= match;
    end
  end

  assign dout  = dout_q;
  assign armed = (state_q == StArmed);

`ifdef SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (pat_ld) begin
      cnt_d = '0;
    end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// Bench for seq_det_param: three configurations driven in parallel and checked every cycle
// against a bit-history model; directed scenarios followed by random traffic.
module tb_seq_det_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, seqin, seq_vld, pat_ld;
  logic [2:0] pat_in3;
  logic [3:0] pat_in4;
  logic       dout_ov, armed_ov, dout_nov, armed_nov, dout_l4, armed_l4;
`ifdef SEQ_DET_MATCH_CNT_EN
  logic [1:0] cnt_ov;
  logic [7:0] cnt_nov;
  logic [2:0] cnt_l4;
`endif

  seq_det_param #(.SEQ_LEN(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CNT_W(2)) u_ov (
    .clk(clk), .rst(rst), .seqin(seqin), .seq_vld(seq_vld), .pat_ld(pat_ld),
    .pat_in(pat_in3), .dout(dout_ov), .armed(armed_ov)
`ifdef SEQ_DET_MATCH_CNT_EN
    , .match_cnt(cnt_ov)
`endif
  );

  seq_det_param #(.SEQ_LEN(3), .PATTERN(3'b101), .OVERLAP(1'b0), .CNT_W(8)) u_nov (
    .clk(clk), .rst(rst), .seqin(seqin), .seq_vld(seq_vld), .pat_ld(pat_ld),
    .pat_in(pat_in3), .dout(dout_nov), .armed(armed_nov)
`ifdef SEQ_DET_MATCH_CNT_EN
    , .match_cnt(cnt_nov)
`endif
  );

  seq_det_param #(.SEQ_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(3)) u_l4 (
    .clk(clk), .rst(rst), .seqin(seqin), .seq_vld(seq_vld), .pat_ld(pat_ld),
    .pat_in(pat_in4), .dout(dout_l4), .armed(armed_l4)
`ifdef SEQ_DET_MATCH_CNT_EN
    , .match_cnt(cnt_l4)
`endif
  );

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned stepn  = 0;

  // Model: per instance, the last bits received since the last clear and how many there are.
  int unsigned m_len[3]  = '{3, 3, 4};
  int unsigned m_rpat[3] = '{5, 5, 13};
  int unsigned m_ov[3]   = '{1, 0, 1};
  int unsigned m_cmax[3] = '{3, 255, 7};
  int unsigned m_pat[3], m_hist[3], m_n[3], m_cnt[3];
  bit          m_dout[3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step %0d: observed %0h expected %0h", tag, stepn, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit ld, input bit v, input bit b,
                            input int unsigned p3, input int unsigned p4);
    for (int i = 0; i < 3; i++) begin
      int unsigned mask;
      mask = (32'd1 << m_len[i]) - 1;
      if (r) begin
        m_pat[i] = m_rpat[i]; m_hist[i] = 0; m_n[i] = 0; m_dout[i] = 0; m_cnt[i] = 0;
      end else if (ld) begin
        m_pat[i] = (i == 2) ? p4 : p3;
        m_hist[i] = 0; m_n[i] = 0; m_dout[i] = 0; m_cnt[i] = 0;
      end else if (v) begin
        m_hist[i] = ((m_hist[i] << 1) | int'(b)) & mask;
        if (m_n[i] < m_len[i]) m_n[i]++;
        m_dout[i] = (m_n[i] == m_len[i]) && (m_hist[i] == m_pat[i]);
        if (m_dout[i]) begin
          if (m_cnt[i] < m_cmax[i]) m_cnt[i]++;
          if (m_ov[i] == 0) begin
            m_hist[i] = 0;
            m_n[i]    = 0;
          end
        end
      end else begin
        m_dout[i] = 0;
      end
    end
  endtask

  task automatic step(input bit r, input bit ld, input bit v, input bit b, input logic [3:0] p);
    rst = r; pat_ld = ld; seq_vld = v; seqin = b; pat_in3 = p[2:0]; pat_in4 = p;
    @(posedge clk);
    #1;
    stepn++;
    model_edge(r, ld, v, b, int'(p[2:0]), int'(p));
    check("ov.dout",    32'(dout_ov),   32'(m_dout[0]));
    check("ov.armed",   32'(armed_ov),  32'(m_n[0] >= m_len[0] - 1));
    check("nov.dout",   32'(dout_nov),  32'(m_dout[1]));
    check("nov.armed",  32'(armed_nov), 32'(m_n[1] >= m_len[1] - 1));
    check("l4.dout",    32'(dout_l4),   32'(m_dout[2]));
    check("l4.armed",   32'(armed_l4),  32'(m_n[2] >= m_len[2] - 1));
`ifdef SEQ_DET_MATCH_CNT_EN
    check("ov.cnt",     32'(cnt_ov),    m_cnt[0]);
    check("nov.cnt",    32'(cnt_nov),   m_cnt[1]);
    check("l4.cnt",     32'(cnt_l4),    m_cnt[2]);
`endif
  endtask

  task automatic bit_in(input bit b);
    step(1'b0, 1'b0, 1'b1, b, 4'b0000);
  endtask

  initial begin
    bit s101[7];
    bit s4[7];
    s101 = '{1, 0, 1, 0, 1, 0, 1};
    s4   = '{1, 1, 0, 1, 1, 0, 1};

    // Reset, then alternating stream: overlap vs non-overlap.
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'b0000);
    for (int i = 0; i < 7; i++) bit_in(s101[i]);

    // Gap in seq_vld with random seqin.
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    bit_in(1'b1);
    bit_in(1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'($urandom), 4'b0000);
    bit_in(1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);

    // Pattern reload to 1101, then stream; pat_ld mid-stream with seq_vld also high.
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'b1101);
    for (int i = 0; i < 7; i++) bit_in(s4[i]);
    bit_in(1'b1);
    bit_in(1'b1);
    bit_in(1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'b1101);
    for (int i = 0; i < 7; i++) bit_in(s4[i]);

    // Reset mid-stream discards history.
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    bit_in(1'b1);
    bit_in(1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'b0000);
    bit_in(1'b1);
    bit_in(1'b0);
    bit_in(1'b1);

    // Five overlapping matches saturate the 2-bit counter, then pat_ld clears it.
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    bit_in(1'b1);
    for (int i = 0; i < 5; i++) begin
      bit_in(1'b0);
      bit_in(1'b1);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'b1101);

    // Random traffic with occasional reloads and resets.
    for (int i = 0; i < 600; i++) begin
      int unsigned sel;
      bit r, ld;
      sel = $urandom_range(0, 99);
      r   = (sel == 0);
      ld  = (sel == 1 || sel == 2);
      step(r, ld, ($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
